// File: rtl/serial_io_fifo.sv
// Memory-mapped serial port with independent RX and TX FIFOs,
// enables, flush, occupancy counts and sticky W1C error flags.
module serial_io_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int RX_DEPTH   = 8,
    parameter int TX_DEPTH   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            cpu_addr_in,
    input  logic                  cpu_re_in,
    input  logic                  cpu_we_in,
    input  logic [31:0]           cpu_wdata_in,
    output logic [31:0]           cpu_rdata_out,
    input  logic [DATA_WIDTH-1:0] serial_in,
    input  logic                  serial_valid_in,
    input  logic                  serial_ready_in,
    output logic [DATA_WIDTH-1:0] serial_out,
    output logic                  serial_rden_out,
    output logic                  serial_wren_out
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_CW = RX_AW + 1;
    localparam int TX_CW = TX_AW + 1;

    logic [DATA_WIDTH-1:0] rx_mem [RX_DEPTH];
    logic [DATA_WIDTH-1:0] tx_mem [TX_DEPTH];

    logic [RX_AW-1:0] rx_wr_ptr;
    logic [RX_AW-1:0] rx_rd_ptr;
    logic [RX_CW-1:0] rx_count;
    logic [TX_AW-1:0] tx_wr_ptr;
    logic [TX_AW-1:0] tx_rd_ptr;
    logic [TX_CW-1:0] tx_count;

    logic rx_en;
    logic tx_en;
    logic tx_drop;
    logic rx_underrun;

    logic rx_empty;
    logic rx_full;
    logic tx_empty;
    logic tx_full;
    logic sel_data;
    logic sel_status;
    logic sel_ctrl;
    logic rx_push;
    logic rx_pop;
    logic tx_push;
    logic tx_pop;
    logic flush;
    logic drop_set;
    logic underrun_set;
    logic drop_clr;
    logic underrun_clr;
    logic [7:0] rx_cnt8;
    logic [7:0] tx_cnt8;
    logic [31:0] status_word;
    logic [31:0] rdata_next;
    logic unused_wdata;

    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == RX_CW'(RX_DEPTH));
    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == TX_CW'(TX_DEPTH));

    assign sel_data   = (cpu_addr_in == 2'd0);
    assign sel_status = (cpu_addr_in == 2'd1);
    assign sel_ctrl   = (cpu_addr_in == 2'd2);

    // Link handshakes are held low while reset is asserted.
    assign serial_rden_out = reset & rx_en & serial_valid_in & ~rx_full;
    assign serial_wren_out = reset & tx_en & serial_ready_in & ~tx_empty;
    assign serial_out = tx_empty ? '0 : tx_mem[tx_rd_ptr];

    assign rx_push = serial_rden_out;
    assign rx_pop  = cpu_re_in & sel_data & ~rx_empty;
    assign tx_push = cpu_we_in & sel_data & ~tx_full;
    assign tx_pop  = serial_wren_out;
    assign flush   = cpu_we_in & sel_ctrl & cpu_wdata_in[2];

    assign drop_set     = cpu_we_in & sel_data & tx_full;
    assign underrun_set = cpu_re_in & sel_data & rx_empty;
    assign drop_clr     = cpu_we_in & sel_status & cpu_wdata_in[4];
    assign underrun_clr = cpu_we_in & sel_status & cpu_wdata_in[5];

    assign rx_cnt8 = 8'(rx_count);
    assign tx_cnt8 = 8'(tx_count);
    assign status_word = {8'd0, tx_cnt8, rx_cnt8, 2'b00,
                          rx_underrun, tx_drop,
                          tx_full, tx_empty, rx_full, rx_empty};

    // Only the byte lane and a few control bits of the write bus are used.
    assign unused_wdata = ^cpu_wdata_in;

    // Read-data mux reflects pre-edge state.
    always_comb begin
        rdata_next = '0;
        unique case (cpu_addr_in)
            2'd0: rdata_next = rx_empty ? '0 : 32'(rx_mem[rx_rd_ptr]);
            2'd1: rdata_next = status_word;
            2'd2: rdata_next = {30'd0, tx_en, rx_en};
            2'd3: rdata_next = '0;
            default: rdata_next = '0;
        endcase
    end

    // FIFO storage; pointers alone define validity, so no reset here.
    always_ff @(posedge clock) begin
        if (rx_push && !flush) rx_mem[rx_wr_ptr] <= serial_in;
        if (tx_push && !flush) tx_mem[tx_wr_ptr] <= cpu_wdata_in[DATA_WIDTH-1:0];
    end

    // RX pointers and occupancy; flush overrides any same-edge traffic.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else if (flush) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            rx_count <= rx_count + RX_CW'(rx_push) - RX_CW'(rx_pop);
        end
    end

    // TX pointers and occupancy; flush overrides any same-edge traffic.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else if (flush) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            tx_count <= tx_count + TX_CW'(tx_push) - TX_CW'(tx_pop);
        end
    end

    // Control, sticky flags and registered read data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_en         <= 1'b1;
            tx_en         <= 1'b1;
            tx_drop       <= 1'b0;
            rx_underrun   <= 1'b0;
            cpu_rdata_out <= '0;
        end else begin
            // A flush command leaves the enables as they were.
            if (cpu_we_in && sel_ctrl && !cpu_wdata_in[2]) begin
                rx_en <= cpu_wdata_in[0];
                tx_en <= cpu_wdata_in[1];
            end
            tx_drop     <= drop_set | (tx_drop & ~drop_clr);
            rx_underrun <= underrun_set | (rx_underrun & ~underrun_clr);
            if (cpu_re_in) cpu_rdata_out <= rdata_next;
        end
    end

endmodule

// File: tb/tb_serial_io_fifo.sv
// Scoreboard bench for serial_io_fifo: CPU reads and TX bytes are
// queued as expectations and checked by an independent monitor.
module tb_serial_io_fifo;

    logic        clock;
    logic        reset;
    logic [1:0]  cpu_addr_in;
    logic        cpu_re_in;
    logic        cpu_we_in;
    logic [31:0] cpu_wdata_in;
    logic [31:0] cpu_rdata_out;
    logic [7:0]  serial_in;
    logic        serial_valid_in;
    logic        serial_ready_in;
    logic [7:0]  serial_out;
    logic        serial_rden_out;
    logic        serial_wren_out;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_rd[$];
    logic [7:0]  exp_tx[$];

    serial_io_fifo #(.DATA_WIDTH(8), .RX_DEPTH(8), .TX_DEPTH(8)) dut (
        .clock(clock),
        .reset(reset),
        .cpu_addr_in(cpu_addr_in),
        .cpu_re_in(cpu_re_in),
        .cpu_we_in(cpu_we_in),
        .cpu_wdata_in(cpu_wdata_in),
        .cpu_rdata_out(cpu_rdata_out),
        .serial_in(serial_in),
        .serial_valid_in(serial_valid_in),
        .serial_ready_in(serial_ready_in),
        .serial_out(serial_out),
        .serial_rden_out(serial_rden_out),
        .serial_wren_out(serial_wren_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got output with no expected value queued", name);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e);
        cpu_addr_in = a;
        cpu_re_in = 1'b1;
        exp_rd.push_back(e);
        step();
        cpu_re_in = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cpu_addr_in = a;
        cpu_we_in = 1'b1;
        cpu_wdata_in = d;
        step();
        cpu_we_in = 1'b0;
    endtask

    // Monitor: compares read data and transmitted bytes against the queues.
    initial begin
        logic fire;
        forever begin
            @(posedge clock);
            fire = cpu_re_in && reset;
            @(negedge clock);
            if (fire) begin
                if (exp_rd.size() == 0) bad("rdata");
                else chk("rdata", cpu_rdata_out, exp_rd.pop_front());
            end
            if (serial_wren_out) begin
                if (exp_tx.size() == 0) bad("serial_out");
                else chk("serial_out", 32'(serial_out), 32'(exp_tx.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0;
        cpu_addr_in = 2'd0;
        cpu_re_in = 1'b0;
        cpu_we_in = 1'b0;
        cpu_wdata_in = '0;
        serial_in = 8'h00;
        serial_valid_in = 1'b1;
        serial_ready_in = 1'b1;

        // Reset state
        #3;
        chk("reset_rden", 32'(serial_rden_out), 0);
        chk("reset_wren", 32'(serial_wren_out), 0);
        chk("reset_rdata", cpu_rdata_out, 0);
        chk("reset_serial_out", 32'(serial_out), 0);
        step();
        serial_valid_in = 1'b0;
        serial_ready_in = 1'b0;
        reset = 1'b1;
        rd(2'd1, 32'h0000_0005);
        rd(2'd2, 32'h0000_0003);

        // 1. RX burst
        serial_valid_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            serial_in = 8'h11 + 8'(i);
            #1;
            chk("rx_burst_rden", 32'(serial_rden_out), 1);
            step();
        end
        serial_in = 8'h19;
        #1;
        chk("rx_full_rden", 32'(serial_rden_out), 0);
        serial_valid_in = 1'b0;
        rd(2'd1, 32'h0000_0806);
        for (int i = 0; i < 8; i++) rd(2'd0, 32'h11 + 32'(i));
        rd(2'd1, 32'h0000_0005);

        // 2. TX backpressure
        wr(2'd0, 32'h0000_00A5);
        wr(2'd0, 32'h0000_005A);
        #1;
        chk("tx_hold_wren", 32'(serial_wren_out), 0);
        rd(2'd1, 32'h0002_0001);
        exp_tx.push_back(8'hA5);
        exp_tx.push_back(8'h5A);
        serial_ready_in = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (serial_wren_out) n++;
            step();
        end
        chk("tx_wren_cycles", 32'(n), 2);
        serial_ready_in = 1'b0;
        chk("tx_drained", 32'(exp_tx.size()), 0);
        rd(2'd1, 32'h0000_0005);

        // 3. Overflow and underrun
        for (int i = 0; i < 9; i++) wr(2'd0, 32'(i + 1));
        rd(2'd0, 32'h0000_0000);
        rd(2'd1, 32'h0008_0039);
        wr(2'd1, 32'h0000_0030);
        rd(2'd1, 32'h0008_0009);
        for (int i = 0; i < 8; i++) exp_tx.push_back(8'(i + 1));
        serial_ready_in = 1'b1;
        repeat (10) step();
        serial_ready_in = 1'b0;
        chk("ovf_drained", 32'(exp_tx.size()), 0);
        rd(2'd1, 32'h0000_0005);

        // 4. Simultaneous push/pop at full
        serial_valid_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            serial_in = 8'h21 + 8'(i);
            step();
        end
        serial_in = 8'h29;
        #1;
        chk("full_rden", 32'(serial_rden_out), 0);
        cpu_addr_in = 2'd0;
        cpu_re_in = 1'b1;
        exp_rd.push_back(32'h21);
        #1;
        chk("full_pop_rden", 32'(serial_rden_out), 0);
        step();
        cpu_re_in = 1'b0;
        #1;
        chk("after_pop_rden", 32'(serial_rden_out), 1);
        step();
        serial_valid_in = 1'b0;
        rd(2'd1, 32'h0000_0806);
        for (int i = 0; i < 8; i++) rd(2'd0, 32'h22 + 32'(i));
        rd(2'd1, 32'h0000_0005);

        // 5. Flush and enables
        serial_valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            serial_in = 8'h31 + 8'(i);
            step();
        end
        serial_valid_in = 1'b0;
        wr(2'd0, 32'h41);
        wr(2'd0, 32'h42);
        wr(2'd0, 32'h43);
        rd(2'd1, 32'h0003_0300);
        wr(2'd2, 32'h0000_0004);
        rd(2'd1, 32'h0000_0005);
        rd(2'd2, 32'h0000_0003);
        wr(2'd2, 32'h0000_0000);
        rd(2'd2, 32'h0000_0000);
        wr(2'd0, 32'h55);
        serial_valid_in = 1'b1;
        serial_ready_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("dis_rden", 32'(serial_rden_out), 0);
            chk("dis_wren", 32'(serial_wren_out), 0);
            step();
        end
        serial_valid_in = 1'b0;
        rd(2'd1, 32'h0001_0001);
        exp_tx.push_back(8'h55);
        wr(2'd2, 32'h0000_0003);
        repeat (3) step();
        serial_ready_in = 1'b0;
        chk("en_drained", 32'(exp_tx.size()), 0);
        rd(2'd1, 32'h0000_0005);

        // 6. Async reset mid-burst
        wr(2'd0, 32'h77);
        serial_valid_in = 1'b1;
        serial_in = 8'h61;
        step();
        serial_in = 8'h62;
        rd(2'd1, 32'h0001_0100);
        serial_in = 8'h63;
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_rden", 32'(serial_rden_out), 0);
        chk("arst_wren", 32'(serial_wren_out), 0);
        chk("arst_rdata", cpu_rdata_out, 0);
        chk("arst_serial_out", 32'(serial_out), 0);
        serial_valid_in = 1'b0;
        step();
        reset = 1'b1;
        rd(2'd1, 32'h0000_0005);
        rd(2'd2, 32'h0000_0003);

        repeat (2) step();
        chk("rd_queue_empty", 32'(exp_rd.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
